// File: rtl/id_ex_control_stage_if.sv
// id_ex_control_stage_if: IF/ID-to-EX handshake and ID/EX control bundle
interface id_ex_control_stage_if;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic        id_ready;
  logic        flush;
  logic        ex_ready;
  logic        id_ex_valid;
  logic [3:0]  id_ex_alu_op;
  logic [1:0]  id_ex_mux_sel;
  logic        id_ex_read_mem;
  logic        id_ex_write_mem;
  logic        id_ex_write_reg;
  logic        id_ex_branch;
  logic [4:0]  id_ex_rd;
  logic        mac_busy;
  logic        illegal_instr;
  modport master (
    output if_id_valid, if_id_instruction, flush, ex_ready,
    input  id_ready, id_ex_valid, id_ex_alu_op, id_ex_mux_sel, id_ex_read_mem,
           id_ex_write_mem, id_ex_write_reg, id_ex_branch, id_ex_rd, mac_busy, illegal_instr
  );
  modport slave (
    input  if_id_valid, if_id_instruction, flush, ex_ready,
    output id_ready, id_ex_valid, id_ex_alu_op, id_ex_mux_sel, id_ex_read_mem,
           id_ex_write_mem, id_ex_write_reg, id_ex_branch, id_ex_rd, mac_busy, illegal_instr
  );
endinterface

// File: rtl/id_ex_control_stage.sv
// id_ex_control_stage: registered decode with load-use stall, flush and MAC occupancy
module id_ex_control_stage #(
  parameter int MAC_CYCLES    = 3,
  parameter bit ENABLE_MAC    = 1'b1,
  parameter bit ENABLE_HAZARD = 1'b1
) (
  input logic clk,
  input logic rst_n,
  id_ex_control_stage_if.slave bus
);
  localparam int CW = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;
  typedef enum logic {ST_RUN, ST_MAC} state_t;
  typedef struct packed {
    logic       valid;
    logic [3:0] alu_op;
    logic [1:0] mux_sel;
    logic       read_mem;
    logic       write_mem;
    logic       write_reg;
    logic       branch;
    logic [4:0] rd;
  } entry_t;
  localparam entry_t BUBBLE = '{1'b0, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        entry_q, entry_d, dec;
  logic          illegal_q, illegal_d;
  logic          legal, use_rs1, use_rs2, is_mac;
  logic          hazard, slot_free, accept;
  logic [6:0]    op, f7;
  logic [2:0]    f3;
  logic [4:0]    rs1, rs2;
  assign op  = bus.if_id_instruction[6:0];
  assign f3  = bus.if_id_instruction[14:12];
  assign f7  = bus.if_id_instruction[31:25];
  assign rs1 = bus.if_id_instruction[19:15];
  assign rs2 = bus.if_id_instruction[24:20];
  // decode the IF/ID instruction into a candidate entry plus source usage
  always_comb begin
    dec       = BUBBLE;
    dec.valid = 1'b1;
    dec.rd    = bus.if_id_instruction[11:7];
    legal     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    is_mac    = 1'b0;
    case (op)
      7'b0110011: begin
        dec.alu_op    = (f7 == 7'b0000000) ? ((f3 == 3'b000) ? 4'd0 : (f3 == 3'b001) ? 4'd5 :
                                              (f3 == 3'b110) ? 4'd4 : (f3 == 3'b111) ? 4'd3 : 4'd15) :
                        (f7 == 7'b0100000) ? ((f3 == 3'b000) ? 4'd1 : (f3 == 3'b101) ? 4'd6 : 4'd15) : 4'd15;
        dec.write_reg = 1'b1;
        legal         = dec.alu_op != 4'd15;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      7'b0010011: begin
        dec.alu_op    = (f3 == 3'b000) ? 4'd2 : (f3 == 3'b110) ? 4'd12 : (f3 == 3'b111) ? 4'd11 : 4'd15;
        dec.mux_sel   = 2'b10;
        dec.write_reg = 1'b1;
        legal         = dec.alu_op != 4'd15;
        use_rs1       = 1'b1;
      end
      7'b0000011: begin
        dec.alu_op    = 4'd7;
        dec.mux_sel   = 2'b10;
        dec.read_mem  = 1'b1;
        dec.write_reg = 1'b1;
        legal         = 1'b1;
        use_rs1       = 1'b1;
      end
      7'b0100011: begin
        dec.alu_op    = 4'd8;
        dec.mux_sel   = 2'b10;
        dec.write_mem = 1'b1;
        legal         = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      7'b1100011: begin
        dec.alu_op    = 4'd9;
        dec.mux_sel   = 2'b11;
        dec.branch    = 1'b1;
        legal         = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      7'b1111111: begin
        dec.alu_op    = 4'd10;
        dec.write_reg = 1'b1;
        legal         = ENABLE_MAC && f7 == 7'b0 && f3 == 3'b0;
        is_mac        = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end
  // handshake, hazard detection, next entry and sequencer next state
  always_comb begin
    hazard    = ENABLE_HAZARD && entry_q.valid && entry_q.read_mem && entry_q.rd != 5'd0 &&
                ((use_rs1 && entry_q.rd == rs1) || (use_rs2 && entry_q.rd == rs2));
    slot_free = ~entry_q.valid | bus.ex_ready;
    accept    = bus.if_id_valid && state_q == ST_RUN && !hazard && slot_free && !bus.flush;
    entry_d   = (bus.flush || slot_free) ? ((accept && legal) ? dec : BUBBLE) : entry_q;
    illegal_d = accept && !legal;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (bus.flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      if (accept && legal && is_mac && MAC_CYCLES > 1) begin
        state_d = ST_MAC;
        cnt_d   = CW'(MAC_CYCLES - 1);
      end
    end else begin
      state_d = (cnt_q == CW'(1)) ? ST_RUN : ST_MAC;
      cnt_d   = (cnt_q == CW'(1)) ? '0 : cnt_q - CW'(1);
    end
  end
  // state, ID/EX entry and illegal pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      entry_q   <= BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      entry_q   <= entry_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.id_ready        = state_q == ST_RUN && !hazard && slot_free && !bus.flush;
  assign bus.id_ex_valid     = entry_q.valid;
  assign bus.id_ex_alu_op    = entry_q.alu_op;
  assign bus.id_ex_mux_sel   = entry_q.mux_sel;
  assign bus.id_ex_read_mem  = entry_q.read_mem;
  assign bus.id_ex_write_mem = entry_q.write_mem;
  assign bus.id_ex_write_reg = entry_q.write_reg;
  assign bus.id_ex_branch    = entry_q.branch;
  assign bus.id_ex_rd        = entry_q.rd;
  assign bus.mac_busy        = state_q == ST_MAC;
  assign bus.illegal_instr   = illegal_q;
endmodule

// File: tb/tb_id_ex_control_stage.sv
// tb_id_ex_control_stage: directed checks on a default instance and a hazard/MAC-disabled instance
module tb_id_ex_control_stage;
  localparam logic [31:0] ADD3 = 32'h002081B3;
  localparam logic [31:0] SUB3 = 32'h402081B3;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00228333;
  localparam logic [31:0] MAC3 = 32'h002081FF;
  localparam logic [31:0] LUI3 = 32'h000001B7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic flush = 1'b0;
  logic ex_ready = 1'b1;
  int checks = 0;
  int errors = 0;
  id_ex_control_stage_if a();
  id_ex_control_stage_if b();
  assign a.if_id_valid = valid;
  assign a.if_id_instruction = instr;
  assign a.flush = flush;
  assign a.ex_ready = ex_ready;
  assign b.if_id_valid = valid;
  assign b.if_id_instruction = instr;
  assign b.flush = flush;
  assign b.ex_ready = ex_ready;
  id_ex_control_stage #(.MAC_CYCLES(3), .ENABLE_MAC(1'b1), .ENABLE_HAZARD(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  id_ex_control_stage #(.MAC_CYCLES(3), .ENABLE_MAC(1'b0), .ENABLE_HAZARD(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #12;
    checks++; if (a.id_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", a.id_ex_valid); end
    checks++; if (a.id_ex_alu_op !== 4'd15) begin errors++; $display("FAIL reset_alu_op: got %0d expected 15", a.id_ex_alu_op); end
    checks++; if ({a.id_ex_mux_sel, a.id_ex_read_mem, a.id_ex_write_mem, a.id_ex_write_reg, a.id_ex_branch, a.id_ex_rd} !== 11'd0) begin errors++; $display("FAIL reset_fields: got %0h expected 0", {a.id_ex_mux_sel, a.id_ex_read_mem, a.id_ex_write_mem, a.id_ex_write_reg, a.id_ex_branch, a.id_ex_rd}); end
    checks++; if ({a.mac_busy, a.illegal_instr} !== 2'b00) begin errors++; $display("FAIL reset_busy_illegal: got %0b expected 00", {a.mac_busy, a.illegal_instr}); end
    checks++; if (a.id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready: got %0b expected 1", a.id_ready); end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_add;
    valid = 1'b1; instr = ADD3; ex_ready = 1'b1;
    #1;
    checks++; if (a.id_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0b expected 1", a.id_ready); end
    step();
    valid = 1'b0;
    checks++; if (a.id_ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b expected 1", a.id_ex_valid); end
    checks++; if (a.id_ex_alu_op !== 4'd0) begin errors++; $display("FAIL add_alu_op: got %0d expected 0", a.id_ex_alu_op); end
    checks++; if (a.id_ex_mux_sel !== 2'b00) begin errors++; $display("FAIL add_mux_sel: got %0b expected 00", a.id_ex_mux_sel); end
    checks++; if ({a.id_ex_write_reg, a.id_ex_read_mem, a.id_ex_write_mem, a.id_ex_branch} !== 4'b1000) begin errors++; $display("FAIL add_ctrl: got %0b expected 1000", {a.id_ex_write_reg, a.id_ex_read_mem, a.id_ex_write_mem, a.id_ex_branch}); end
    checks++; if (a.id_ex_rd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d expected 3", a.id_ex_rd); end
    step();
    checks++; if (a.id_ex_valid !== 1'b0 || a.id_ex_alu_op !== 4'd15) begin errors++; $display("FAIL add_bubble: got valid %0b alu %0d expected 0/15", a.id_ex_valid, a.id_ex_alu_op); end
  endtask
  task automatic test_load_use;
    valid = 1'b1; instr = LW5;
    step();
    instr = ADD6;
    #1;
    checks++; if (a.id_ex_read_mem !== 1'b1 || a.id_ex_alu_op !== 4'd7 || a.id_ex_mux_sel !== 2'b10) begin errors++; $display("FAIL lw_entry: got rm %0b alu %0d mux %0b expected 1/7/10", a.id_ex_read_mem, a.id_ex_alu_op, a.id_ex_mux_sel); end
    checks++; if (a.id_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready: got %0b expected 0", a.id_ready); end
    checks++; if (b.id_ready !== 1'b1) begin errors++; $display("FAIL nohazard_ready: got %0b expected 1", b.id_ready); end
    step();
    checks++; if (a.id_ex_valid !== 1'b0 || a.id_ex_alu_op !== 4'd15) begin errors++; $display("FAIL hazard_bubble: got valid %0b alu %0d expected 0/15", a.id_ex_valid, a.id_ex_alu_op); end
    checks++; if (b.id_ex_valid !== 1'b1 || b.id_ex_rd !== 5'd6) begin errors++; $display("FAIL nohazard_issue: got valid %0b rd %0d expected 1/6", b.id_ex_valid, b.id_ex_rd); end
    checks++; if (a.id_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %0b expected 1", a.id_ready); end
    step();
    valid = 1'b0;
    checks++; if (a.id_ex_valid !== 1'b1 || a.id_ex_alu_op !== 4'd0 || a.id_ex_rd !== 5'd6) begin errors++; $display("FAIL hazard_issue: got valid %0b alu %0d rd %0d expected 1/0/6", a.id_ex_valid, a.id_ex_alu_op, a.id_ex_rd); end
    step();
  endtask
  task automatic test_mac;
    valid = 1'b1; instr = MAC3;
    step();
    instr = SUB3;
    #1;
    checks++; if (a.id_ex_valid !== 1'b1 || a.id_ex_alu_op !== 4'd10 || a.mac_busy !== 1'b1) begin errors++; $display("FAIL mac_issue: got valid %0b alu %0d busy %0b expected 1/10/1", a.id_ex_valid, a.id_ex_alu_op, a.mac_busy); end
    checks++; if (a.id_ready !== 1'b0) begin errors++; $display("FAIL mac_ready1: got %0b expected 0", a.id_ready); end
    checks++; if (b.illegal_instr !== 1'b1 || b.id_ex_valid !== 1'b0) begin errors++; $display("FAIL mac_disabled: got illegal %0b valid %0b expected 1/0", b.illegal_instr, b.id_ex_valid); end
    step();
    checks++; if (a.mac_busy !== 1'b1 || a.id_ready !== 1'b0 || a.id_ex_valid !== 1'b0) begin errors++; $display("FAIL mac_cycle2: got busy %0b ready %0b valid %0b expected 1/0/0", a.mac_busy, a.id_ready, a.id_ex_valid); end
    checks++; if (b.illegal_instr !== 1'b0) begin errors++; $display("FAIL mac_disabled_pulse: got %0b expected 0", b.illegal_instr); end
    step();
    checks++; if (a.mac_busy !== 1'b0 || a.id_ready !== 1'b1) begin errors++; $display("FAIL mac_done: got busy %0b ready %0b expected 0/1", a.mac_busy, a.id_ready); end
    step();
    valid = 1'b0;
    checks++; if (a.id_ex_valid !== 1'b1 || a.id_ex_alu_op !== 4'd1) begin errors++; $display("FAIL mac_next: got valid %0b alu %0d expected 1/1", a.id_ex_valid, a.id_ex_alu_op); end
    step();
  endtask
  task automatic test_stall;
    valid = 1'b1; instr = ADD3; ex_ready = 1'b1;
    step();
    instr = SUB3; ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a.id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %0b expected 0", i, a.id_ready); end
      step();
      checks++; if (a.id_ex_valid !== 1'b1 || a.id_ex_alu_op !== 4'd0 || a.id_ex_rd !== 5'd3) begin errors++; $display("FAIL stall_hold%0d: got valid %0b alu %0d rd %0d expected 1/0/3", i, a.id_ex_valid, a.id_ex_alu_op, a.id_ex_rd); end
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (a.id_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %0b expected 1", a.id_ready); end
    step();
    valid = 1'b0;
    checks++; if (a.id_ex_valid !== 1'b1 || a.id_ex_alu_op !== 4'd1) begin errors++; $display("FAIL stall_next: got valid %0b alu %0d expected 1/1", a.id_ex_valid, a.id_ex_alu_op); end
    step();
  endtask
  task automatic test_flush;
    valid = 1'b1; instr = MAC3;
    step();
    instr = ADD3; flush = 1'b1;
    #1;
    checks++; if (a.mac_busy !== 1'b1 || a.id_ready !== 1'b0) begin errors++; $display("FAIL flush_pre: got busy %0b ready %0b expected 1/0", a.mac_busy, a.id_ready); end
    step();
    flush = 1'b0;
    #1;
    checks++; if (a.id_ex_valid !== 1'b0 || a.mac_busy !== 1'b0) begin errors++; $display("FAIL flush_clear: got valid %0b busy %0b expected 0/0", a.id_ex_valid, a.mac_busy); end
    checks++; if (a.id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b expected 1", a.id_ready); end
    step();
    instr = LUI3; flush = 1'b1;
    checks++; if (a.id_ex_valid !== 1'b1 || a.id_ex_alu_op !== 4'd0) begin errors++; $display("FAIL flush_next: got valid %0b alu %0d expected 1/0", a.id_ex_valid, a.id_ex_alu_op); end
    step();
    flush = 1'b0; valid = 1'b0;
    checks++; if (a.illegal_instr !== 1'b0 || a.id_ex_valid !== 1'b0) begin errors++; $display("FAIL flush_illegal: got illegal %0b valid %0b expected 0/0", a.illegal_instr, a.id_ex_valid); end
    step();
  endtask
  task automatic test_illegal;
    valid = 1'b1; instr = LUI3;
    step();
    valid = 1'b0;
    checks++; if (a.illegal_instr !== 1'b1 || a.id_ex_valid !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got illegal %0b valid %0b expected 1/0", a.illegal_instr, a.id_ex_valid); end
    step();
    checks++; if (a.illegal_instr !== 1'b0) begin errors++; $display("FAIL illegal_end: got %0b expected 0", a.illegal_instr); end
  endtask
  task automatic test_reset_mid_mac;
    valid = 1'b1; instr = MAC3;
    step();
    valid = 1'b0;
    checks++; if (a.mac_busy !== 1'b1) begin errors++; $display("FAIL rmac_busy: got %0b expected 1", a.mac_busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (a.mac_busy !== 1'b0 || a.id_ex_valid !== 1'b0 || a.id_ex_alu_op !== 4'd15) begin errors++; $display("FAIL rmac_reset: got busy %0b valid %0b alu %0d expected 0/0/15", a.mac_busy, a.id_ex_valid, a.id_ex_alu_op); end
    step();
    rst_n = 1'b1;
    step();
  endtask
  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_mac();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_control_stage.md
Name: id_ex_control_stage

Overview:
- Registered, parametrised successor to the combinational decode controller.
- Decodes the IF/ID instruction (R, I, L, S, B, MAC formats) into one ID/EX control entry behind a valid/ready handshake.
- Adds load-use hazard stalling, branch flush, a multi-cycle MAC occupancy sequencer, illegal-instruction flagging, and fully defined (latch-free) controls.
- Sits between the IF/ID register and the EX stage.

Parameters:
- MAC_CYCLES, 3: cycles the MAC unit is occupied per MAC instruction (≥1).
- ENABLE_MAC, 1: 0 makes opcode 7'b1111111 illegal.
- ENABLE_HAZARD, 1: 0 disables the load-use stall; the forwarding network then owns correctness.

Ports:
- clk, input, 1: clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- if_id_valid, input, 1: instruction present.
- if_id_instruction, input, 32: RV32-style encoding.
- id_ready, output, 1: ID accepts this cycle (combinational).
- flush, input, 1: branch-taken squash.
- ex_ready, input, 1: EX accepts the ID/EX entry.
- id_ex_valid, output, 1: entry valid.
- id_ex_alu_op, output, 4: ADD=0, SUB=1, ADDI=2, AND=3, OR=4, SLL=5, SRA=6, LW=7, SW=8, BR=9, MAC=10, ANDI=11, ORI=12, NOP=15.
- id_ex_mux_sel, output, 2: R/MAC=00; I/L/S=10; B=11.
- id_ex_read_mem, output, 1: load.
- id_ex_write_mem, output, 1: store.
- id_ex_write_reg, output, 1: writes rd.
- id_ex_branch, output, 1: branch.
- id_ex_rd, output, 5: instruction[11:7].
- mac_busy, output, 1: sequencer in MAC state.
- illegal_instr, output, 1: one-cycle pulse.

Behaviour:
- Reset (asynchronous): id_ex_valid=0, id_ex_alu_op=15, all other id_ex_* = 0, mac_busy=0, illegal_instr=0, state=RUN, counter=0.
- Decode (combinational):
  - R-type, f7=0000000: f3 000=ADD, 001=SLL, 110=OR, 111=AND. f7=0100000: f3 000=SUB, 101=SRA.
  - I-type: f3 000=ADDI, 110=ORI, 111=ANDI.
  - L/S/B: any f3 → LW / SW / BR.
  - MAC: f7=0 and f3=0 only.
  - Everything else is illegal.
  - Every control has a defined value on every path; there are no latches.
- Source use:
  - R, S, B and MAC read rs1 [19:15] and rs2 [24:20].
  - I and L read rs1 only.
- hazard = ENABLE_HAZARD & id_ex_valid & id_ex_read_mem & (id_ex_rd != 0) & (rd matches a used source).
- Handshake:
  - slot_free = ~id_ex_valid | ex_ready.
  - id_ready = (state==RUN) & ~hazard & slot_free & ~flush.
  - Accept = if_id_valid & id_ready.
- ID/EX register, updated only when slot_free:
  - Legal accept: load the decoded entry, id_ex_valid=1.
  - Otherwise (bubble): id_ex_valid=0 and alu_op=NOP.
  - When ~slot_free, hold all fields.
  - Latency: 1 cycle from accept to id_ex_valid.
- Illegal accept: consumes the instruction, issues a bubble, and illegal_instr=1 on the next cycle only.
- Load-use hazard: a bubble is inserted; the instruction stays at IF/ID and is accepted the cycle after the load leaves ID/EX.
- MAC sequencer (two states):
  - RUN: on a MAC accept with MAC_CYCLES>1, go to MAC with counter=MAC_CYCLES-1.
  - MAC: mac_busy=1, id_ready=0; decrement the counter each cycle; return to RUN when it reaches 1.
  - Net effect: the next instruction is accepted exactly MAC_CYCLES cycles after the MAC accept.
  - MAC_CYCLES=1: no MAC state is entered.
- Flush (highest priority):
  - Next edge: id_ex_valid=0, state=RUN, counter=0, mac_busy=0.
  - The incoming instruction is not accepted (id_ready=0).
  - Flush coinciding with hazard, MAC or illegal: flush wins; illegal_instr is suppressed.
- Reset asserted mid-MAC or mid-stall: immediate return to reset values.

Test Plan:
- Reset, then 0x002081B3 (add x3,x1,x2) valid, ex_ready=1 → next cycle id_ex_valid=1, alu_op=0, mux_sel=00, write_reg=1, rd=3.
- lw x5,0(x1) (0x0000A283), then add x6,x5,x2 → one bubble (id_ex_valid=0, alu_op=15), id_ready=0 for 1 cycle, add issued the following cycle. Repeat with ENABLE_HAZARD=0 → no bubble.
- MAC (0x002081FF) with MAC_CYCLES=3, next instruction held valid → mac_busy=1 for 2 cycles, next instruction accepted 3 cycles after the MAC.
- ex_ready=0 for 4 cycles with a valid entry → entry fields stable, id_ready=0; entry retires when ex_ready=1.
- flush during MAC state plus a new valid instruction → id_ex_valid=0, mac_busy=0 next cycle, instruction accepted one cycle later.
- Opcode 7'b0110111 → illegal_instr pulses 1 cycle, no valid entry issued. Same test with ENABLE_MAC=0 and a MAC opcode → identical result.
